// File: rtl/apb_pkg.sv
`timescale 1ns/1ps
// Shared types and default field widths for the APB master bridge.
package apb_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StSetup  = 2'd1,
    StAccess = 2'd2
  } apb_state_e;

  localparam int unsigned ApbAddrWidth = 8;
  localparam int unsigned ApbDataWidth = 8;
  localparam int unsigned ApbTimeout   = 16;

endpackage

// File: rtl/apb_timeout_cnt.sv
`timescale 1ns/1ps
// Saturating ACCESS-phase wait counter; expired flags the last permitted wait cycle.
module apb_timeout_cnt #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  // TIMEOUT=0 still needs a one-bit counter so the declarations stay legal.
  localparam int unsigned CntW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CntW-1:0] CntMax = {CntW{1'b1}};

  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en && (cnt_q != CntMax)) begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end

  always_comb begin
    expired = 1'b0;
    if (TIMEOUT != 0) begin
      expired = (cnt_q == CntW'(TIMEOUT - 1));
    end
  end

endmodule

// File: rtl/apb_master_bridge.sv
`timescale 1ns/1ps
// Single-outstanding valid/ready to APB requester with ACCESS-phase timeout.
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = ApbAddrWidth,
  parameter int unsigned DATA_WIDTH = ApbDataWidth,
  parameter int unsigned TIMEOUT    = ApbTimeout
) (
  input  logic                  pclk,
  input  logic                  preset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_slverr,
  output logic                  rsp_timeout,
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic [DATA_WIDTH-1:0] pwdata,
  input  logic [DATA_WIDTH-1:0] prdata,
  input  logic                  pready,
  input  logic                  pslverr
);

  apb_state_e state_q, state_d;

  logic                  capture;
  logic                  done;
  logic                  abort;
  logic                  cnt_clr;
  logic                  cnt_en;
  logic                  expired;

  logic                  pwrite_q;
  logic [ADDR_WIDTH-1:0] paddr_q;
  logic [DATA_WIDTH-1:0] pwdata_q;
  logic                  rsp_valid_q;
  logic [DATA_WIDTH-1:0] rsp_rdata_q;
  logic                  rsp_slverr_q;
  logic                  rsp_timeout_q;

  apb_timeout_cnt #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout_cnt (
    .clk     (pclk),
    .rst     (preset),
    .clr     (cnt_clr),
    .en      (cnt_en),
    .expired (expired)
  );

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // psel/penable decode straight from state so reset drops them without waiting for a clock.
  always_comb begin
    state_d   = state_q;
    cmd_ready = 1'b0;
    psel      = 1'b0;
    penable   = 1'b0;
    capture   = 1'b0;
    done      = 1'b0;
    abort     = 1'b0;
    cnt_clr   = 1'b0;
    cnt_en    = 1'b0;
    unique case (state_q)
      StIdle: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          capture = 1'b1;
          state_d = StSetup;
        end
      end
      StSetup: begin
        psel    = 1'b1;
        cnt_clr = 1'b1;
        state_d = StAccess;
      end
      StAccess: begin
        psel    = 1'b1;
        penable = 1'b1;
        if (pready) begin
          done    = 1'b1;
          state_d = StIdle;
        end else if (expired) begin
          abort   = 1'b1;
          state_d = StIdle;
        end else begin
          cnt_en = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      pwrite_q <= 1'b0;
      paddr_q  <= '0;
      pwdata_q <= '0;
    end else if (capture) begin
      pwrite_q <= cmd_write;
      paddr_q  <= cmd_addr;
      // Reads leave pwdata at its previous value.
      if (cmd_write) begin
        pwdata_q <= cmd_wdata;
      end
    end
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_slverr_q  <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      rsp_valid_q <= done || abort;
      if (done) begin
        rsp_rdata_q   <= pwrite_q ? '0 : prdata;
        rsp_slverr_q  <= pslverr;
        rsp_timeout_q <= 1'b0;
      end else if (abort) begin
        rsp_rdata_q   <= '0;
        rsp_slverr_q  <= 1'b1;
        rsp_timeout_q <= 1'b1;
      end
    end
  end

  assign pwrite      = pwrite_q;
  assign paddr       = paddr_q;
  assign pwdata      = pwdata_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_slverr  = rsp_slverr_q;
  assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
`timescale 1ns/1ps
// Directed bench for apb_master_bridge against a small timer-register completer model.
module tb_apb_master_bridge;

  logic       pclk = 1'b0;
  logic       preset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_write;
  logic [7:0] cmd_addr;
  logic [7:0] cmd_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_slverr;
  logic       rsp_timeout;
  logic       psel;
  logic       penable;
  logic       pwrite;
  logic [7:0] paddr;
  logic [7:0] pwdata;
  logic [7:0] prdata;
  logic       pready;
  logic       pslverr;

  int compared   = 0;
  int mismatched = 0;

  // Completer model: tdr at 0x00, tcr at 0x01, everything else errors.
  logic [7:0] tdr_reg;
  logic [7:0] tcr_reg;
  int         waits = 0;
  logic       hang  = 1'b0;
  int         wait_cnt;

  always #5 pclk = ~pclk;

  apb_master_bridge #(
    .ADDR_WIDTH(8),
    .DATA_WIDTH(8),
    .TIMEOUT   (4)
  ) dut (
    .pclk        (pclk),
    .preset      (preset),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .rsp_slverr  (rsp_slverr),
    .rsp_timeout (rsp_timeout),
    .psel        (psel),
    .penable     (penable),
    .pwrite      (pwrite),
    .paddr       (paddr),
    .pwdata      (pwdata),
    .prdata      (prdata),
    .pready      (pready),
    .pslverr     (pslverr)
  );

  assign pready  = psel && penable && !hang && (wait_cnt == waits);
  assign pslverr = (paddr > 8'h01);
  assign prdata  = pwrite ? 8'hFF : (paddr == 8'h00) ? tdr_reg :
                   (paddr == 8'h01) ? tcr_reg : 8'hEE;

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      wait_cnt <= 0;
    end else if (psel && penable && !pready) begin
      wait_cnt <= wait_cnt + 1;
    end else begin
      wait_cnt <= 0;
    end
  end

  always_ff @(posedge pclk) begin
    if (psel && penable && pready && pwrite) begin
      if (paddr == 8'h00) tdr_reg <= pwdata;
      if (paddr == 8'h01) tcr_reg <= pwdata;
    end
  end

  // Results of the most recent transfer.
  int   lat;
  int   acc_cycles;
  logic setup_ok;
  logic paddr_ok;
  logic got;

  task automatic run_xfer(input logic w, input logic [7:0] a, input logic [7:0] d);
    int guard;
    @(negedge pclk);
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    guard     = 0;
    while (!cmd_ready && guard < 20) begin
      @(negedge pclk);
      guard++;
    end
    compared++;
    if (!cmd_ready) begin
      mismatched++;
      $display("FAIL accept: cmd_ready=%b required 1", cmd_ready);
    end
    @(posedge pclk);
    #1 cmd_valid = 1'b0;
    lat        = 0;
    acc_cycles = 0;
    setup_ok   = 1'b0;
    paddr_ok   = 1'b1;
    got        = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge pclk);
      lat++;
      if (lat == 1) setup_ok = psel && !penable;
      if (psel && penable) acc_cycles++;
      if (psel && paddr !== a) paddr_ok = 1'b0;
      if (rsp_valid) got = 1'b1;
    end
    compared++;
    if (!got) begin
      mismatched++;
      $display("FAIL rsp_seen: rsp_valid never rose for addr %h", a);
    end
  endtask

  task automatic test_reset;
    preset    = 1'b1;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    repeat (2) @(negedge pclk);
    compared++;
    if ({psel, penable, pwrite, rsp_valid, rsp_slverr, rsp_timeout} !== 6'b0) begin
      mismatched++;
      $display("FAIL reset_ctrl: got %b required 000000",
               {psel, penable, pwrite, rsp_valid, rsp_slverr, rsp_timeout});
    end
    compared++;
    if ({paddr, pwdata, rsp_rdata} !== 24'h0) begin
      mismatched++;
      $display("FAIL reset_data: got %h required 000000", {paddr, pwdata, rsp_rdata});
    end
    preset = 1'b0;
    @(negedge pclk);
    compared++;
    if (cmd_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL reset_ready: cmd_ready=%b required 1", cmd_ready);
    end
  endtask

  task automatic test_write;
    waits = 0;
    run_xfer(1'b1, 8'h00, 8'hA5);
    compared++;
    if (lat !== 3 || !setup_ok || acc_cycles !== 1) begin
      mismatched++;
      $display("FAIL write_timing: lat=%0d setup=%b acc=%0d required 3 1 1",
               lat, setup_ok, acc_cycles);
    end
    compared++;
    if (rsp_slverr !== 1'b0 || rsp_timeout !== 1'b0 || rsp_rdata !== 8'h00) begin
      mismatched++;
      $display("FAIL write_rsp: slverr=%b to=%b rdata=%h required 0 0 00",
               rsp_slverr, rsp_timeout, rsp_rdata);
    end
    compared++;
    if (cmd_ready !== 1'b1 || psel !== 1'b0) begin
      mismatched++;
      $display("FAIL write_idle: cmd_ready=%b psel=%b required 1 0", cmd_ready, psel);
    end
    @(negedge pclk);
    compared++;
    if (rsp_valid !== 1'b0 || tdr_reg !== 8'hA5) begin
      mismatched++;
      $display("FAIL write_after: rsp_valid=%b tdr=%h required 0 a5", rsp_valid, tdr_reg);
    end
  endtask

  task automatic test_read;
    run_xfer(1'b0, 8'h00, 8'h00);
    compared++;
    if (lat !== 3 || rsp_rdata !== 8'hA5 || rsp_slverr !== 1'b0 || rsp_timeout !== 1'b0) begin
      mismatched++;
      $display("FAIL read_tdr: lat=%0d rdata=%h slverr=%b to=%b required 3 a5 0 0",
               lat, rsp_rdata, rsp_slverr, rsp_timeout);
    end
    compared++;
    if (pwdata !== 8'hA5) begin
      mismatched++;
      $display("FAIL read_pwdata_hold: pwdata=%h required a5", pwdata);
    end
    @(negedge pclk);
    compared++;
    if (rsp_valid !== 1'b0 || rsp_rdata !== 8'hA5) begin
      mismatched++;
      $display("FAIL read_hold: rsp_valid=%b rdata=%h required 0 a5", rsp_valid, rsp_rdata);
    end
  endtask

  // Three waits with TIMEOUT=4: pready lands on the expiry cycle and must win.
  task automatic test_wait_states;
    waits = 0;
    run_xfer(1'b1, 8'h01, 8'h3C);
    waits = 3;
    run_xfer(1'b0, 8'h01, 8'h00);
    compared++;
    if (acc_cycles !== 4 || lat !== 6 || !paddr_ok) begin
      mismatched++;
      $display("FAIL wait_timing: acc=%0d lat=%0d paddr_ok=%b required 4 6 1",
               acc_cycles, lat, paddr_ok);
    end
    compared++;
    if (rsp_rdata !== 8'h3C || rsp_slverr !== 1'b0 || rsp_timeout !== 1'b0) begin
      mismatched++;
      $display("FAIL wait_rsp: rdata=%h slverr=%b to=%b required 3c 0 0",
               rsp_rdata, rsp_slverr, rsp_timeout);
    end
    waits = 0;
  endtask

  task automatic test_slverr;
    run_xfer(1'b0, 8'h05, 8'h00);
    compared++;
    if (rsp_slverr !== 1'b1 || rsp_timeout !== 1'b0 || rsp_rdata !== 8'hEE || lat !== 3) begin
      mismatched++;
      $display("FAIL slverr: slverr=%b to=%b rdata=%h lat=%0d required 1 0 ee 3",
               rsp_slverr, rsp_timeout, rsp_rdata, lat);
    end
  endtask

  task automatic test_timeout;
    hang = 1'b1;
    run_xfer(1'b0, 8'h00, 8'h00);
    compared++;
    if (acc_cycles !== 4 || lat !== 6) begin
      mismatched++;
      $display("FAIL timeout_timing: acc=%0d lat=%0d required 4 6", acc_cycles, lat);
    end
    compared++;
    if (rsp_slverr !== 1'b1 || rsp_timeout !== 1'b1 || rsp_rdata !== 8'h00) begin
      mismatched++;
      $display("FAIL timeout_rsp: slverr=%b to=%b rdata=%h required 1 1 00",
               rsp_slverr, rsp_timeout, rsp_rdata);
    end
    hang = 1'b0;
    run_xfer(1'b0, 8'h00, 8'h00);
    compared++;
    if (lat !== 3 || rsp_rdata !== 8'hA5 || rsp_timeout !== 1'b0) begin
      mismatched++;
      $display("FAIL timeout_recover: lat=%0d rdata=%h to=%b required 3 a5 0",
               lat, rsp_rdata, rsp_timeout);
    end
  endtask

  task automatic test_reset_mid;
    logic saw_rsp;
    hang = 1'b1;
    @(negedge pclk);
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 8'h01;
    @(posedge pclk);
    #1 cmd_valid = 1'b0;
    @(negedge pclk);
    @(negedge pclk);
    compared++;
    if (psel !== 1'b1 || penable !== 1'b1) begin
      mismatched++;
      $display("FAIL mid_access: psel=%b penable=%b required 1 1", psel, penable);
    end
    #2 preset = 1'b1;
    #1;
    compared++;
    if (psel !== 1'b0 || penable !== 1'b0) begin
      mismatched++;
      $display("FAIL mid_reset_drop: psel=%b penable=%b required 0 0", psel, penable);
    end
    hang    = 1'b0;
    saw_rsp = 1'b0;
    @(negedge pclk);
    preset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge pclk);
      if (rsp_valid) saw_rsp = 1'b1;
    end
    compared++;
    if (saw_rsp !== 1'b0 || cmd_ready !== 1'b1 || rsp_slverr !== 1'b0) begin
      mismatched++;
      $display("FAIL mid_reset_after: rsp_seen=%b cmd_ready=%b slverr=%b required 0 1 0",
               saw_rsp, cmd_ready, rsp_slverr);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_wait_states();
    test_slverr();
    test_timeout();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/apb_master_bridge.md
# apb_master_bridge

Single-outstanding APB requester that turns a simple valid/ready command interface into APB SETUP/ACCESS transfers and returns a one-cycle response pulse with read data and error status. It sits between a host-side controller (CPU stub, test sequencer, or config FSM) and APB completers such as the timer register block. It adds a programmable ACCESS-phase timeout so a hung completer can never stall the host.

## Interface
- ADDR_WIDTH, 8, width of paddr / cmd_addr
- DATA_WIDTH, 8, width of pwdata / prdata / cmd_wdata / rsp_rdata
- TIMEOUT, 16, max cycles spent in ACCESS waiting for pready; 0 disables timeout
- pclk  in  1  clock; all logic on rising edge
- preset  in  1  asynchronous, active-high reset
- cmd_valid  in  1  host request present
- cmd_ready  out  1  bridge can accept a request
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_WIDTH  target address
- cmd_wdata  in  DATA_WIDTH  write data
- rsp_valid  out  1  one-cycle pulse: transfer finished
- rsp_rdata  out  DATA_WIDTH  read data (0 for writes and timeouts)
- rsp_slverr  out  1  completer pslverr, or timeout
- rsp_timeout  out  1  transfer ended by timeout
- psel, penable, pwrite  out  1  APB control
- paddr  out  ADDR_WIDTH  APB address
- pwdata  out  DATA_WIDTH  APB write data
- prdata  in  DATA_WIDTH  APB read data
- pready  in  1  completer ready
- pslverr  in  1  completer error

## Operation
- States: IDLE, SETUP, ACCESS.
- IDLE: cmd_ready=1, psel=0, penable=0. On cmd_valid&cmd_ready, capture write/addr/wdata into paddr/pwrite/pwdata registers -> SETUP.
- SETUP: psel=1, penable=0, exactly one cycle -> ACCESS. Timeout counter cleared.
- ACCESS: psel=1, penable=1; paddr/pwrite/pwdata held stable for the whole transfer.
  - pready=1 sampled: capture prdata (reads only, else 0) and pslverr; assert rsp_valid next cycle; -> IDLE.
  - pready=0: counter increments; if TIMEOUT!=0 and counter reaches TIMEOUT-1 with pready still 0, abort: rsp_valid=1, rsp_slverr=1, rsp_timeout=1, rsp_rdata=0; -> IDLE.
  - pready and timeout in the same cycle: pready wins (normal completion, rsp_timeout=0).
- cmd_ready=0 in SETUP/ACCESS; host must hold cmd_* until handshake. Only one transfer outstanding.
- rsp_* registered; rsp_rdata/rsp_slverr/rsp_timeout hold last value until next completion; rsp_valid high exactly one cycle.
- pwdata on reads: held at last value (don't-care to completer); paddr/pwrite/pwdata keep last values in IDLE.
- Counter width: $clog2(TIMEOUT+1), saturating; never wraps.

## Timing
- Reset (async assert, sync-safe deassert): state=IDLE, psel=penable=pwrite=0, paddr=0, pwdata=0, rsp_valid=0, rsp_rdata=0, rsp_slverr=0, rsp_timeout=0, counter=0; cmd_ready=1 after reset.
- Handshake at edge N -> SETUP cycle N+1 -> ACCESS from N+2; zero-wait completer: pready at N+2, rsp_valid at N+3, cmd_ready high again at N+3.
- Each wait state adds one cycle; minimum 3 cycles between accepted commands.
- Timeout: ACCESS lasts exactly TIMEOUT cycles, rsp_valid on the following cycle.
- Reset mid-transfer: psel/penable drop immediately, no rsp_valid is generated for the aborted transfer.

## Structure
- Package apb_pkg: state enum (IDLE/SETUP/ACCESS, 2-bit), shared APB field widths defaults.
- Sub-module apb_timeout_cnt: clear/enable/saturating counter with expiry flag, parameter TIMEOUT.
- Top holds FSM, address/data capture and response registers.

## Test plan
- Write 0x00 <- 0xA5 to the timer register block (0 waits) -> psel at N+1, penable at N+2, rsp_valid at N+3, rsp_slverr=0, tdr_reg=0xA5.
- Read 0x00 after the write -> rsp_rdata=0xA5, rsp_slverr=0, rsp_timeout=0.
- Completer with 3 wait states, read 0x01 -> penable high 4 cycles, paddr stable throughout, rsp_rdata matches tcr_reg.
- Read invalid address 0x05 -> rsp_slverr=1, rsp_timeout=0.
- TIMEOUT=4, pready tied 0 -> ACCESS lasts 4 cycles, rsp_slverr=1, rsp_timeout=1, rsp_rdata=0, next command accepted.
- Assert preset during ACCESS -> psel/penable=0 same cycle, no rsp_valid, cmd_ready=1 after release.
